sar_conv_sched: RTL
===================

SAR_CONV_SCHED -- requirements
Module: sar_conv_sched

Interface
REQ-001 Parameter NCH, default 4: number of analog channels sharing one SAR converter.
REQ-002 Parameter NBITS, default 10: SAR result width.
REQ-003 Parameter SAMPLE_CYC, default 4: cycles the sample switch is held closed; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYC, default 64: maximum cycles waited for sar_done; legal range 2..65535.
REQ-005 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 req  in  NCH  per-channel conversion request, level.
REQ-008 ack  out  NCH  one-hot, one-cycle pulse: result for that channel is on dout.
REQ-009 dout  out  NBITS  captured conversion result.
REQ-010 ch_sel  out  clog2(NCH)  analog mux select.
REQ-011 sample  out  1  sample switch enable.
REQ-012 sar_start  out  1  one-cycle start pulse to sar_logic.
REQ-013 sar_done  in  1  end-of-conversion pulse from sar_logic.
REQ-014 sar_result  in  NBITS  sar_logic result, valid when sar_done=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky timeout flag.
REQ-017 err_clr  in  1  clears timeout_err.

Function
REQ-018 FSM states: IDLE, SAMPLE, START, CONVERT, DONE; exactly one state active.
REQ-019 IDLE: if any req bit is set, grant one channel by round-robin, register it on ch_sel, go to SAMPLE; otherwise stay.
REQ-020 Round-robin: search starts at the channel after the last granted channel and wraps from NCH-1 to 0; after reset the search starts at channel 0.
REQ-021 The priority pointer advances on every grant, including grants that end in timeout.
REQ-022 ch_sel changes only on the IDLE->SAMPLE transition and is otherwise held.
REQ-023 SAMPLE: sample=1 for exactly SAMPLE_CYC cycles, then go to START.
REQ-024 START: sar_start=1 for exactly one cycle, then go to CONVERT; sample=0.
REQ-025 CONVERT: on sar_done=1, capture sar_result into dout and go to DONE.
REQ-026 CONVERT: if sar_done has not arrived after TIMEOUT_CYC cycles, set timeout_err, leave dout unchanged, issue no ack, and return to IDLE.
REQ-027 DONE: ack bit of the granted channel =1 for one cycle, then go to IDLE.
REQ-028 Latency: req seen in IDLE at cycle 0 gives sample high in cycles 1..SAMPLE_CYC and sar_start in cycle SAMPLE_CYC+1; ack follows sar_done by one cycle.
REQ-029 Minimum spacing between two acks is SAMPLE_CYC+4 cycles.
REQ-030 sar_done outside CONVERT is ignored.
REQ-031 A req deasserted after grant does not abort the conversion; the ack is still issued.
REQ-032 dout holds its last captured value until the next capture.
REQ-033 Setting timeout_err takes priority over err_clr when both occur in the same cycle.

Reset
REQ-034 On wb_rst_i=1, at the next edge: state=IDLE, ack=0, dout=0, ch_sel=0, sample=0, sar_start=0, busy=0, timeout_err=0, pointer=channel 0.
REQ-035 Reset asserted mid-conversion aborts it with no ack; a sar_done arriving after reset is ignored.

Structure
REQ-036 Package sar_pkg holds the FSM state enum, the NBITS/NCH defaults, and the counter-width constants.
REQ-037 Round-robin selection is one sub-module, rr_arbiter: inputs req and last-grant pointer, output one-hot grant; purely combinational.
REQ-038 One shared down-counter serves both SAMPLE and CONVERT, sized for max(SAMPLE_CYC, TIMEOUT_CYC).

Verification
REQ-039 Single request: req=4'b0010, with a model returning sar_result=10'h2A5 five cycles after sar_start -> ch_sel=1, sample high exactly 4 cycles, one sar_start, ack=4'b0010 with dout=10'h2A5.
REQ-040 Fairness: req=4'b1111 held for 8 conversions -> grant order 0,1,2,3,0,1,2,3; each ack pulse one-hot.
REQ-041 Timeout: sar_done never returned -> timeout_err=1 after 64 CONVERT cycles, no ack, next grant goes to the next channel; err_clr=1 -> timeout_err=0.
REQ-042 Reset mid-CONVERT, then sar_done pulse -> all outputs at reset values, no ack, dout=0.
REQ-043 req withdrawn during SAMPLE -> conversion completes and ack still pulses for that channel; spurious sar_done in IDLE -> no ack, state unchanged.
REQ-044 Back-to-back conversions on channels 2 then 3 -> acks spaced exactly SAMPLE_CYC+4 cycles apart with the sar_done model at minimum delay.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and sizing constants for the SAR conversion scheduler.
// Holds the FSM state encoding, default channel/result widths and counter sizing.
package sar_pkg;

  localparam int SAR_NCH_DEF     = 4;
  localparam int SAR_NBITS_DEF   = 10;
  localparam int SAR_SAMPLE_MAX  = 255;
  localparam int SAR_TIMEOUT_MAX = 65535;
  localparam int SAR_CNT_W_MAX   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_START   = 3'd2,
    ST_CONVERT = 3'd3,
    ST_DONE    = 3'd4
  } sar_state_e;

  // The shared down-counter is loaded with (cycles - 1), so the width only
  // has to hold values up to max(sample_cyc, timeout_cyc) - 1.
  function automatic int sar_cnt_w(input int sample_cyc, input int timeout_cyc);
    int m;
    m = (sample_cyc > timeout_cyc) ? sample_cyc : timeout_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requesting
// channel after last_i, wrapping from NCH-1 back to 0.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [NCH-1:0]  grant_o
);

  int              sum;
  logic [CH_W-1:0] idx;

  // Walk from the lowest-priority slot (last_i itself) to the highest
  // (last_i + 1); the final hit overwrites earlier ones and wins.
  always_comb begin
    grant_o = '0;
    sum     = 0;
    idx     = '0;
    for (int i = NCH; i >= 1; i--) begin
      sum = (int'(last_i) + i) % NCH;
      idx = CH_W'(sum);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_conv_sched.sv
// Schedules NCH analog channels onto one SAR converter: round-robin grant,
// timed sample window, start pulse, bounded wait for end-of-conversion, ack.
module sar_conv_sched
  import sar_pkg::*;
#(
  parameter int NCH         = SAR_NCH_DEF,
  parameter int NBITS       = SAR_NBITS_DEF,
  parameter int SAMPLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   ack,
  output logic [NBITS-1:0] dout,
  output logic [CH_W-1:0]  ch_sel,
  output logic             sample,
  output logic             sar_start,
  input  logic             sar_done,
  input  logic [NBITS-1:0] sar_result,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic [2:0]       state_dbg
);

  localparam int              CNT_W        = sar_cnt_w(SAMPLE_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD  = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  sar_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CH_W-1:0]  last_q;
  logic [CH_W-1:0]  sel_q;
  logic [NCH-1:0]   grant_q;
  logic [NCH-1:0]   ack_q;
  logic [NBITS-1:0] dout_q;
  logic             sample_q;
  logic             start_q;
  logic             busy_q;
  logic             terr_q;

  logic [NCH-1:0]   grant_d;
  logic [CH_W-1:0]  sel_d;

  rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr_arbiter (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (grant_d)
  );

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_d[i]) sel_d = CH_W'(i);
    end
  end

  // last_q resets to NCH-1 so the first search after reset begins at channel 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= CH_W'(NCH - 1);
      sel_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      dout_q   <= '0;
      sample_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      if (err_clr) terr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            last_q   <= sel_d;
            cnt_q    <= SAMPLE_LOAD;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (cnt_q == '0) begin
            sample_q <= 1'b0;
            start_q  <= 1'b1;
            state_q  <= ST_START;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_START: begin
          cnt_q   <= TIMEOUT_LOAD;
          state_q <= ST_CONVERT;
        end
        ST_CONVERT: begin
          // A timeout set here overrides the err_clr clear issued above.
          if (sar_done) begin
            dout_q  <= sar_result;
            ack_q   <= grant_q;
            state_q <= ST_DONE;
          end else if (cnt_q == '0) begin
            terr_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          sample_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign dout        = dout_q;
  assign ch_sel      = sel_q;
  assign sample      = sample_q;
  assign sar_start   = start_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule
